// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// the reset-time NOP encoding and a word-alignment helper.
package fetch_unit_pkg;

  localparam logic [1:0] PC_MUX_PC4     = 2'b00;
  localparam logic [1:0] PC_MUX_BRANCH  = 2'b01;
  localparam logic [1:0] PC_MUX_ALU_OUT = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_target_sel.sv
// Combinational redirect decode: decides whether the execute stage is
// redirecting fetch this cycle and, if so, to which word-aligned target.
module pc_target_sel
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  branch,
  input  logic        branch_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] alu_out,
  output logic        redirect,
  output logic [31:0] target
);

  // Select target; PC_MUX_PC4 and the unused code 2'b11 never redirect
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (branch_valid) begin
      case (branch)
        PC_MUX_BRANCH: begin
          redirect = 1'b1;
          target   = word_align(ex_pc + ex_imm);
        end
        PC_MUX_ALU_OUT: begin
          redirect = 1'b1;
          target   = word_align(alu_out);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, hands the
// returned word to decode, and tracks execute-stage redirects, discarding
// any in-flight response that a redirect has made stale.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  branch,
  input  logic        branch_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic        kill, kill_next;
  logic        if_valid_next;
  logic [31:0] if_instr_next, if_pc_next;
  logic        redirect;
  logic [31:0] target;

  pc_target_sel u_pc_target_sel (
    .branch       (branch),
    .branch_valid (branch_valid),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .alu_out      (alu_out),
    .redirect     (redirect),
    .target       (target)
  );

  assign imem_addr = req_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, request strobe and datapath next values
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    kill_next     = kill;
    if_valid_next = if_valid;
    if_instr_next = if_instr;
    if_pc_next    = if_pc;
    imem_req      = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) begin
          pc_next       = target;
          req_addr_next = target;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (kill || redirect) begin
            // Stale response: drop it and reissue at the newest PC
            kill_next     = 1'b0;
            req_addr_next = redirect ? target : pc;
            if (redirect) pc_next = target;
          end else begin
            if_instr_next = imem_rdata;
            if_pc_next    = req_addr;
            if_valid_next = 1'b1;
            pc_next       = req_addr + 32'd4;
            state_next    = HOLD;
          end
        end else if (redirect) begin
          // Request address must stay put until the ack; remember to drop it
          kill_next = 1'b1;
          pc_next   = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          if_valid_next = 1'b0;
          pc_next       = target;
          req_addr_next = target;
          state_next    = FETCH;
        end else if (if_ready) begin
          if_valid_next = 1'b0;
          req_addr_next = pc;
          state_next    = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
    end else begin
      pc       <= pc_next;
      req_addr <= req_addr_next;
      kill     <= kill_next;
      if_valid <= if_valid_next;
      if_instr <= if_instr_next;
      if_pc    <= if_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, with delivered instructions checked by a scoreboard fed
// from a stream-level model of the expected PC sequence.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic        branch_valid = 1'b0;
  logic [31:0] ex_pc = '0, ex_imm = '0, alu_out = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_valid, if_ready = 1'b1;
  logic [31:0] if_instr, if_pc;

  // Second instance with a reset PC at the top of the address space
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_deliv  = 0;
  int unsigned mem_mode = 1;   // 0 random ack, 1 ack every request, 2 never ack, 3 spurious ack
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .branch(branch), .branch_valid(branch_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .alu_out(alu_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .branch(2'b00), .branch_valid(1'b0),
    .ex_pc(32'h0), .ex_imm(32'h0), .alu_out(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_ready(1'b1)
  );

  // Instruction memory contents: a fixed function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign w_rdata = mem_word(w_addr);

  function automatic logic is_redirect();
    return branch_valid && (branch == 2'b01 || branch == 2'b10);
  endfunction

  function automatic logic [31:0] redirect_target();
    logic [31:0] t;
    t = (branch == 2'b01) ? ex_pc + ex_imm : alu_out;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Expected delivery stream: sequential words from the latest start point
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    exp_tail = start;
    refill();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic drive(input logic bv, input logic [1:0] br, input logic [31:0] p,
                       input logic [31:0] imm, input logic [31:0] alu);
    branch_valid = bv;
    branch       = br;
    ex_pc        = p;
    ex_imm       = imm;
    alu_out      = alu;
    if (is_redirect()) model_restart(redirect_target());
  endtask

  // Instruction memory responder
  initial begin
    forever begin
      @(negedge clk);
      case (mem_mode)
        0: imem_ack = imem_req && ($urandom_range(0, 2) == 0);
        1: imem_ack = imem_req;
        2: imem_ack = 1'b0;
        default: imem_ack = 1'b1;
      endcase
      imem_rdata = (mem_mode == 3) ? 32'hDEAD_BEEF : mem_word(imem_addr);
    end
  end

  // Monitor: scoreboard pops on each delivery, plus handshake stability
  initial begin
    logic        pv, preq, pack;
    logic [31:0] p_pc, p_instr, paddr, e;
    pv = 1'b0; preq = 1'b0; pack = 1'b0;
    p_pc = '0; p_instr = '0; paddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0; preq = 1'b0; pack = 1'b0;
        continue;
      end
      if (pv) begin
        check1("hold_valid", if_valid, 1'b1);
        check("hold_pc", if_pc, p_pc);
        check("hold_instr", if_instr, p_instr);
      end
      if (preq && !pack) begin
        check1("req_held", imem_req, 1'b1);
        check("req_addr_stable", imem_addr, paddr);
      end
      if (if_valid && if_ready && !is_redirect()) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: got pc %h expected no delivery", if_pc);
        end else begin
          e = exp_q.pop_front();
          n_deliv++;
          check("deliv_pc", if_pc, e);
          check("deliv_instr", if_instr, mem_word(e));
        end
      end
      pv      = if_valid && !if_ready && !is_redirect();
      p_pc    = if_pc;
      p_instr = if_instr;
      preq    = imem_req;
      pack    = imem_ack;
      paddr   = imem_addr;
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br;
    logic        bv;
    logic [31:0] pv_r, imm, alu;
    int unsigned r;

    model_restart(32'h0);
    #1 rst = 1'b1;
    #1;
    check1("rst_if_valid", if_valid, 1'b0);
    check1("rst_imem_req", imem_req, 1'b0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_wrap_if_pc", w_pc, 32'hFFFF_FFFC);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check1("rst_hold_req", imem_req, 1'b0);
    rst = 1'b0;

    // Back-to-back fetch with an always-ready consumer
    for (int k = 1; k <= 6; k++) begin
      step();
      check1("thr_req", imem_req, (k % 2) == 1);
      check1("thr_valid", if_valid, (k % 2) == 0);
      if (k % 2 == 1) check("thr_addr", imem_addr, 32'(4 * ((k - 1) / 2)));
      if (k % 2 == 0) check("thr_if_pc", if_pc, 32'(4 * ((k - 2) / 2)));
      if (k == 1) check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      if (k == 2) check("wrap_first_pc", w_pc, 32'hFFFF_FFFC);
      if (k == 3) check("wrap_second_addr", w_addr, 32'h0000_0000);
      if (k == 4) check("wrap_second_pc", w_pc, 32'h0000_0000);
    end

    // Decode stalls for five cycles
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check1("stall_valid", if_valid, 1'b1);
      check("stall_pc", if_pc, 32'h8);
      check("stall_instr", if_instr, mem_word(32'h8));
      check1("stall_no_req", imem_req, 1'b0);
    end

    // Branch back by 8 from 0x100 while holding
    mem_mode = 2;
    drive(1'b1, 2'b01, 32'h100, 32'hFFFF_FFF8, 32'h0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    check1("br_valid_drop", if_valid, 1'b0);
    check1("br_req", imem_req, 1'b1);
    check("br_addr", imem_addr, 32'hF8);

    // Jump to misaligned 0x203 while the 0xF8 request is outstanding
    drive(1'b1, 2'b10, 32'h0, 32'h0, 32'h203);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("kill_addr_c1", imem_addr, 32'hF8);
    step();
    check("kill_addr_c2", imem_addr, 32'hF8);
    step();
    mem_mode = 1;
    check("kill_addr_c3", imem_addr, 32'hF8);
    step();
    check("kill_new_addr", imem_addr, 32'h200);
    check1("kill_req", imem_req, 1'b1);
    check1("kill_no_valid", if_valid, 1'b0);
    step();
    check("jump_if_pc", if_pc, 32'h200);
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Randomized traffic
    mem_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;
        model_restart(32'h0);
        step();
        rst = 1'b0;
        continue;
      end
      r    = $urandom_range(0, 15);
      bv   = (r < 4);
      br   = 2'($urandom_range(0, 3));
      pv_r = $urandom;
      imm  = 32'($urandom_range(0, 4095)) - 32'd2048;
      alu  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(bv, br, pv_r, imm, alu);
    end

    // Reset while a request is pending, then a stale ack after release
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    if_ready = 1'b1;
    mem_mode = 2;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    check1("pend_req", imem_req, 1'b1);
    rst = 1'b1;
    model_restart(32'h0);
    #1;
    check1("mid_rst_req", imem_req, 1'b0);
    check1("mid_rst_valid", if_valid, 1'b0);
    check("mid_rst_instr", if_instr, NOP);
    check("mid_rst_if_pc", if_pc, 32'h0);
    step();
    rst = 1'b0;
    mem_mode = 3;
    step();
    mem_mode = 1;
    check1("late_ack_no_valid", if_valid, 1'b0);
    check1("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 32'h0);
    step();
    check1("post_rst_valid", if_valid, 1'b1);
    check("post_rst_if_pc", if_pc, 32'h0);
    for (int k = 0; k < 4; k++) step();

    check1("deliveries_seen", n_deliv > 100, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC fetched first after reset.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: branch  in  2  next-PC select from branch stage (PC_MUX_* encoding).
REQ-005 SHALL have ports: branch_valid  in  1  execute stage resolving an instruction this cycle.
REQ-006 SHALL have ports: ex_pc  in  32  PC of resolving instruction; ex_imm  in  32  sign-extended branch offset.
REQ-007 SHALL have ports: alu_out  in  32  jump target from ALU.
REQ-008 SHALL have ports: imem_req  out  1; imem_addr  out  32; imem_ack  in  1; imem_rdata  in  32  (instruction memory handshake).
REQ-009 SHALL have ports: if_valid  out  1; if_instr  out  32; if_pc  out  32; if_ready  in  1  (decode handshake).

Function
REQ-010 Redirect SHALL occur when branch_valid=1 and branch!=PC_MUX_PC4; target = ex_pc+ex_imm for PC_MUX_BRANCH, alu_out for PC_MUX_ALU_OUT, target[1:0] forced to 2'b00.
REQ-011 branch=2'b11 SHALL be treated as PC_MUX_PC4 (no redirect).
REQ-012 FSM states SHALL be IDLE, FETCH, HOLD; reset state IDLE; IDLE->FETCH unconditionally next cycle.
REQ-013 imem_req SHALL be 1 exactly in FETCH; imem_addr SHALL come from a req_addr register, stable from request until the ack cycle.
REQ-014 Transfer completes on a cycle with imem_req=1 and imem_ack=1 (ack in first request cycle allowed, imem_rdata sampled that edge).
REQ-015 FETCH, ack, no kill, no redirect: if_instr<=imem_rdata, if_pc<=req_addr, if_valid<=1, pc<=req_addr+4, -> HOLD.
REQ-016 HOLD: if_valid, if_instr, if_pc SHALL stay stable until if_valid&if_ready; then if_valid<=0, req_addr<=pc, -> FETCH.
REQ-017 Throughput SHALL be one instruction per 2 cycles minimum (zero-wait memory, if_ready=1).
REQ-018 Redirect in HOLD SHALL take priority over if_ready: if_valid<=0, pc<=target, req_addr<=target, -> FETCH.
REQ-019 Redirect in FETCH without ack SHALL set kill<=1 and pc<=target; req_addr unchanged.
REQ-020 Ack with kill=1 or simultaneous redirect SHALL discard imem_rdata, clear kill, req_addr<=target-or-pc, stay FETCH; if_valid stays 0.
REQ-021 Further redirects while kill=1 SHALL overwrite pc; last one wins.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-023 Redirect in IDLE SHALL load pc and req_addr with target.

Reset
REQ-024 On rst=1, immediately: state=IDLE, pc=req_addr=RESET_PC, kill=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, imem_req=0.
REQ-025 Reset mid-transaction SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored.

Structure
REQ-026 PC_MUX_PC4=2'b00, PC_MUX_BRANCH=2'b01, PC_MUX_ALU_OUT=2'b10 SHALL come from shared include pc_mux.v; state codes local.
REQ-027 Target selection SHALL be a combinational sub-module pc_target_sel; rest in fetch_unit.

Verification
REQ-028 Reset, ack every request, if_ready=1 -> imem_addr 0x0,0x4,0x8 on FETCH cycles; if_pc matches; if_valid every 2nd cycle.
REQ-029 HOLD with if_ready=0 for 5 cycles -> if_valid, if_instr, if_pc unchanged; no imem_req.
REQ-030 Branch ex_pc=0x100, ex_imm=-8 in HOLD -> if_valid drops next cycle, next imem_addr=0xF8.
REQ-031 alu_out=0x203 with PC_MUX_ALU_OUT during FETCH, ack 3 cycles later -> rdata discarded, imem_addr stays old until ack, then 0x200.
REQ-032 RESET_PC=0xFFFF_FFFC -> second fetch at 0x0000_0000.
REQ-033 rst asserted during pending FETCH, ack after release -> no if_valid from stale ack; first post-reset fetch at RESET_PC.
